marker_region_locator: RTL and testbench

- Streaming stage directly upstream of the byte-mask generator in pattern_matcher.
- Scans 64-bit packet words for a programmable start-marker byte and end-marker byte, tracking region state across words.
- For every word it emits the 3-bit high/low lane indices (out_first/out_last) that the mask generator turns into an 8-bit byte-enable.
- Lane 7 (bits 63:56) is the first byte on the wire; a region within a word spans lanes out_first down to out_last inclusive.

---
 rtl/pattern_pkg.sv | 29 ++
 rtl/lane_priority_find.sv | 39 +++
 rtl/marker_region_locator.sv | 244 ++++++++++++++++++++++++
 tb/tb_marker_region_locator.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/pattern_pkg.sv
// ---------------------------------------------------------------------------
// pattern_pkg
// Shared definitions for the pattern_matcher streaming stages.
//   LANES / LANE_W / BYTE_W : word geometry (8 lanes of 8 bits, 3-bit index)
//   lane_t                  : lane index type, lane 7 = bits 63:56 (first byte)
//   state_t                 : region tracking state (outside / inside region)
//   lane_byte()             : extracts one byte lane from a packet word
// ---------------------------------------------------------------------------
package pattern_pkg;

    localparam int LANES  = 8;
    localparam int LANE_W = 3;
    localparam int BYTE_W = 8;

    typedef logic [LANE_W-1:0] lane_t;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_INSIDE = 1'b1
    } state_t;

    function automatic logic [BYTE_W-1:0] lane_byte(
        input logic [LANES*BYTE_W-1:0] word,
        input lane_t                   lane
    );
        return word[{lane, 3'b000} +: BYTE_W];
    endfunction

endpackage

// File: rtl/lane_priority_find.sv
// ---------------------------------------------------------------------------
// lane_priority_find
// Combinational search for the highest byte lane equal to match_byte, limited
// to lanes at or below an upper bound.
//   in_word    : 64-bit packet word
//   match_byte : byte value searched for
//   bound      : upper lane limit
//   bound_incl : 1 = bound lane itself is searched, 0 = only lanes below it
//   found      : at least one lane matched within the limit
//   lane       : highest matching lane (0 when nothing found)
// ---------------------------------------------------------------------------
module lane_priority_find
    import pattern_pkg::*;
(
    input  logic [LANES*BYTE_W-1:0] in_word,
    input  logic [BYTE_W-1:0]       match_byte,
    input  lane_t                   bound,
    input  logic                    bound_incl,
    output logic                    found,
    output lane_t                   lane
);

    // Ascending sweep; a later (higher) match overwrites, so the highest wins.
    always_comb begin
        found = 1'b0;
        lane  = 3'd0;
        for (int i = 0; i < LANES; i++) begin
            if ((lane_byte(in_word, lane_t'(i)) == match_byte) &&
                (bound_incl ? (lane_t'(i) <= bound) : (lane_t'(i) < bound))) begin
                found = 1'b1;
                lane  = lane_t'(i);
            end else begin
                found = found;
                lane  = lane;
            end
        end
    end

endmodule

// File: rtl/marker_region_locator.sv
// ---------------------------------------------------------------------------
// marker_region_locator
// Scans 64-bit packet words for a start-marker byte and an end-marker byte and
// reports, per word, the lane range (out_first down to out_last) covered by a
// marker-delimited region. Region state is carried across words of a packet.
// One-cycle registered pipeline stage with valid/ready handshake.
//
//   clk, reset_n            : clock, asynchronous active-low reset
//   cfg_start_byte/end_byte : marker values (must differ)
//   in_data/sop/eop/valid   : upstream word, in_ready back-pressure
//   out_data/sop/eop/valid  : registered copy of the accepted word
//   out_ready               : downstream accepts
//   out_hit                 : word contains region bytes
//   out_first / out_last    : highest / lowest region lane in the word
//   out_trunc               : region cut by eop or by span abort in this word
//
// Optional build macro REGION_LOCATOR_STATS_EN adds saturating counters
// stat_regions (regions closed by an end marker) and stat_truncs.
// ---------------------------------------------------------------------------
module marker_region_locator
    import pattern_pkg::*;
#(
    parameter int DATA_W         = 64,
    parameter int MAX_SPAN_WORDS = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [7:0]        cfg_start_byte,
    input  logic [7:0]        cfg_end_byte,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_sop,
    input  logic              in_eop,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_sop,
    output logic              out_eop,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_hit,
    output logic [2:0]        out_first,
    output logic [2:0]        out_last,
    output logic              out_trunc
`ifdef REGION_LOCATOR_STATS_EN
    ,
    output logic [15:0]       stat_regions,
    output logic [15:0]       stat_truncs
`endif
);

    localparam int                SPAN_W   = $clog2(MAX_SPAN_WORDS + 1);
    localparam logic [SPAN_W-1:0] SPAN_MAX = SPAN_W'(MAX_SPAN_WORDS);

    state_t             state_q, state_d;
    logic [SPAN_W-1:0]  span_q, span_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic               sop_q, sop_d, eop_q, eop_d, valid_q, valid_d;
    logic               hit_q, hit_d, trunc_q, trunc_d;
    lane_t              first_q, first_d, last_q, last_d;

    logic               accept_s, inside_s;
    logic               s_found_s, e_found_s;
    lane_t              s_lane_s, e_lane_s;
    logic               w_hit_s, w_trunc_s, w_open_s, w_closed_s;
    lane_t              w_first_s, w_last_s;
    state_t             w_state_s;
    logic [SPAN_W-1:0]  span_step_s, w_span_s;

    assign in_ready = !valid_q || out_ready;
    assign accept_s = in_valid && in_ready;

    // A sop while a region is open means the previous eop went missing:
    // the word is scanned as if the stage were idle.
    assign inside_s = (state_q == ST_INSIDE) && !in_sop;

    lane_priority_find u_start_find (
        .in_word    (in_data),
        .match_byte (cfg_start_byte),
        .bound      (3'd7),
        .bound_incl (1'b1),
        .found      (s_found_s),
        .lane       (s_lane_s)
    );

    // Inside a region the whole word is searched; otherwise only the lanes
    // strictly after (below) the start marker can hold its end marker.
    lane_priority_find u_end_find (
        .in_word    (in_data),
        .match_byte (cfg_end_byte),
        .bound      (inside_s ? 3'd7 : s_lane_s),
        .bound_incl (inside_s),
        .found      (e_found_s),
        .lane       (e_lane_s)
    );

    // Per-word region decode: lane range, next state, span and truncation.
    always_comb begin
        w_hit_s     = 1'b0;
        w_first_s   = 3'd0;
        w_last_s    = 3'd0;
        w_open_s    = 1'b0;
        w_closed_s  = 1'b0;
        span_step_s = '0;
        if (inside_s) begin
            w_hit_s   = 1'b1;
            w_first_s = 3'd7;
            if (e_found_s) begin
                w_last_s   = e_lane_s;
                w_closed_s = 1'b1;
            end else begin
                w_open_s    = 1'b1;
                span_step_s = span_q + SPAN_W'(1);
            end
        end else if (s_found_s) begin
            w_hit_s   = 1'b1;
            w_first_s = s_lane_s;
            if (e_found_s) begin
                w_last_s   = e_lane_s;
                w_closed_s = 1'b1;
            end else begin
                w_open_s    = 1'b1;
                span_step_s = SPAN_W'(1);
            end
        end else begin
            w_hit_s = 1'b0;
        end

        // last is already 0 whenever the region is still open after the scan.
        if (w_open_s && (in_eop || (span_step_s >= SPAN_MAX))) begin
            w_trunc_s = 1'b1;
            w_state_s = ST_IDLE;
            w_span_s  = '0;
        end else if (w_open_s) begin
            w_trunc_s = 1'b0;
            w_state_s = ST_INSIDE;
            w_span_s  = span_step_s;
        end else begin
            w_trunc_s = 1'b0;
            w_state_s = ST_IDLE;
            w_span_s  = '0;
        end
    end

    // Pipeline register next-state: load on accept, drop valid once taken.
    always_comb begin
        state_d = state_q;
        span_d  = span_q;
        data_d  = data_q;
        sop_d   = sop_q;
        eop_d   = eop_q;
        hit_d   = hit_q;
        first_d = first_q;
        last_d  = last_q;
        trunc_d = trunc_q;
        valid_d = valid_q;
        if (accept_s) begin
            state_d = w_state_s;
            span_d  = w_span_s;
            data_d  = in_data;
            sop_d   = in_sop;
            eop_d   = in_eop;
            hit_d   = w_hit_s;
            first_d = w_first_s;
            last_d  = w_last_s;
            trunc_d = w_trunc_s;
            valid_d = 1'b1;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            span_q  <= '0;
            data_q  <= '0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            hit_q   <= 1'b0;
            first_q <= 3'd0;
            last_q  <= 3'd0;
            trunc_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            span_q  <= span_d;
            data_q  <= data_d;
            sop_q   <= sop_d;
            eop_q   <= eop_d;
            hit_q   <= hit_d;
            first_q <= first_d;
            last_q  <= last_d;
            trunc_q <= trunc_d;
            valid_q <= valid_d;
        end
    end

    assign out_data  = data_q;
    assign out_sop   = sop_q;
    assign out_eop   = eop_q;
    assign out_valid = valid_q;
    assign out_hit   = hit_q;
    assign out_first = first_q;
    assign out_last  = last_q;
    assign out_trunc = trunc_q;

`ifdef REGION_LOCATOR_STATS_EN
    logic [15:0] regions_q, regions_d, truncs_q, truncs_d;

    // Saturating event counters.
    always_comb begin
        regions_d = regions_q;
        truncs_d  = truncs_q;
        if (accept_s && w_closed_s && (regions_q != 16'hFFFF)) begin
            regions_d = regions_q + 16'd1;
        end else begin
            regions_d = regions_q;
        end
        if (accept_s && w_trunc_s && (truncs_q != 16'hFFFF)) begin
            truncs_d = truncs_q + 16'd1;
        end else begin
            truncs_d = truncs_q;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            regions_q <= 16'd0;
            truncs_q  <= 16'd0;
        end else begin
            regions_q <= regions_d;
            truncs_q  <= truncs_d;
        end
    end

    assign stat_regions = regions_q;
    assign stat_truncs  = truncs_q;
`endif

endmodule

// File: tb/tb_marker_region_locator.sv
// ---------------------------------------------------------------------------
// tb_marker_region_locator
// Directed, table-driven bench for marker_region_locator (MAX_SPAN_WORDS=4),
// plus hand-written back-pressure and asynchronous-reset sequences.
// ---------------------------------------------------------------------------
module tb_marker_region_locator;

    localparam logic [7:0]  SB = 8'h3C;
    localparam logic [7:0]  EB = 8'h3E;
    localparam logic [63:0] BG = 64'h1111_1111_1111_1111;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  cfg_start_byte = SB;
    logic [7:0]  cfg_end_byte = EB;
    logic [63:0] in_data = 64'd0;
    logic        in_sop = 1'b0, in_eop = 1'b0, in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] out_data;
    logic        out_sop, out_eop, out_valid;
    logic        out_ready = 1'b1;
    logic        out_hit, out_trunc;
    logic [2:0]  out_first, out_last;
`ifdef REGION_LOCATOR_STATS_EN
    logic [15:0] stat_regions, stat_truncs;
`endif

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    marker_region_locator #(.DATA_W(64), .MAX_SPAN_WORDS(4)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .cfg_start_byte (cfg_start_byte),
        .cfg_end_byte   (cfg_end_byte),
        .in_data        (in_data),
        .in_sop         (in_sop),
        .in_eop         (in_eop),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .out_data       (out_data),
        .out_sop        (out_sop),
        .out_eop        (out_eop),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_hit        (out_hit),
        .out_first      (out_first),
        .out_last       (out_last),
        .out_trunc      (out_trunc)
`ifdef REGION_LOCATOR_STATS_EN
        ,
        .stat_regions   (stat_regions),
        .stat_truncs    (stat_truncs)
`endif
    );

    typedef struct {
        logic [63:0] data;
        logic        sop;
        logic        eop;
        logic        hit;
        logic [2:0]  first;
        logic [2:0]  last;
        logic        trunc;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [63:0] put(input logic [63:0] w, input int lane, input logic [7:0] b);
        logic [63:0] r;
        r = w;
        r[lane*8 +: 8] = b;
        return r;
    endfunction

    task automatic add(input logic [63:0] d, input logic s, input logic e,
                       input logic h, input logic [2:0] f, input logic [2:0] l, input logic t);
        vec_t v;
        v.data = d; v.sop = s; v.eop = e; v.hit = h; v.first = f; v.last = l; v.trunc = t;
        vecs.push_back(v);
    endtask

    // {valid, hit, first, last, trunc, sop, eop, data}
    function automatic logic [74:0] outs();
        return {out_valid, out_hit, out_first, out_last, out_trunc, out_sop, out_eop, out_data};
    endfunction

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [63:0] d, input logic s, input logic e);
        in_data = d; in_sop = s; in_eop = e; in_valid = 1'b1;
    endtask

    initial begin
        // Single word region, start lane 6, end lane 2.
        add(put(put(BG, 6, SB), 2, EB), 1, 1, 1, 3'd6, 3'd2, 0);
        // Three-word region.
        add(put(BG, 1, SB), 1, 0, 1, 3'd1, 3'd0, 0);
        add(BG,             0, 0, 1, 3'd7, 3'd0, 0);
        add(put(BG, 5, EB), 0, 1, 1, 3'd7, 3'd5, 0);
        // Open region truncated by eop.
        add(put(BG, 4, SB), 1, 0, 1, 3'd4, 3'd0, 0);
        add(BG,             0, 1, 1, 3'd7, 3'd0, 1);
        // Next packet starts idle: lone end marker is not a hit.
        add(put(BG, 3, EB), 1, 1, 0, 3'd0, 3'd0, 0);
        // End marker above the start is ignored; region open, cut by eop.
        add(put(put(BG, 6, EB), 3, SB), 1, 1, 1, 3'd3, 3'd0, 1);
        // Two starts: highest wins; end in lane 0.
        add(put(put(put(BG, 7, SB), 5, SB), 0, EB), 1, 1, 1, 3'd7, 3'd0, 0);
        // Start after end in same word is not rescanned.
        add(put(put(put(BG, 2, SB), 1, EB), 0, SB), 1, 0, 1, 3'd2, 3'd1, 0);
        add(BG,             0, 1, 0, 3'd0, 3'd0, 0);
        // sop while inside: treated as idle word.
        add(put(BG, 6, SB), 1, 0, 1, 3'd6, 3'd0, 0);
        add(put(BG, 4, EB), 1, 0, 0, 3'd0, 3'd0, 0);
        add(BG,             0, 1, 0, 3'd0, 3'd0, 0);
        // Start bytes inside an open region are ignored.
        add(put(BG, 7, SB), 1, 0, 1, 3'd7, 3'd0, 0);
        add(put(put(BG, 6, SB), 2, EB), 0, 1, 1, 3'd7, 3'd2, 0);
        // Span abort with MAX_SPAN_WORDS=4 in a 10-word packet.
        add(put(BG, 0, SB), 1, 0, 1, 3'd0, 3'd0, 0);
        add(BG, 0, 0, 1, 3'd7, 3'd0, 0);
        add(BG, 0, 0, 1, 3'd7, 3'd0, 0);
        add(BG, 0, 0, 1, 3'd7, 3'd0, 1);
        for (int k = 0; k < 5; k++) add(BG, 0, 0, 0, 3'd0, 3'd0, 0);
        add(BG, 0, 1, 0, 3'd0, 3'd0, 0);
        // sop while inside with start+end: idle-style scan gives (5,3).
        add(put(BG, 2, SB), 1, 0, 1, 3'd2, 3'd0, 0);
        add(put(put(BG, 5, SB), 3, EB), 1, 1, 1, 3'd5, 3'd3, 0);

        // Reset state.
        @(posedge clk); #1;
        chk("reset_outs", 96'(outs()), 96'd0);
        chk("reset_in_ready", 96'(in_ready), 96'd1);
        reset_n = 1'b1;

        // Table-driven streaming, one word per cycle.
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].data, vecs[i].sop, vecs[i].eop);
            out_ready = 1'b1;
            @(posedge clk); #1;
            chk($sformatf("vec%0d", i), 96'(outs()),
                96'({1'b1, vecs[i].hit, vecs[i].first, vecs[i].last, vecs[i].trunc,
                     vecs[i].sop, vecs[i].eop, vecs[i].data}));
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("drain_valid", 96'(out_valid), 96'd0);

        // Back-pressure: A held for 3 cycles, then B and C each exactly once.
        drive(put(BG, 6, SB), 1, 0);
        @(posedge clk); #1;
        out_ready = 1'b0;
        drive(put(BG, 3, EB), 0, 1);
        #1;
        chk("bp_in_ready", 96'(in_ready), 96'd0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk($sformatf("bp_hold%0d", c), 96'({outs(), in_ready}),
                96'({1'b1, 1'b1, 3'd6, 3'd0, 1'b0, 1'b1, 1'b0, put(BG, 6, SB), 1'b0}));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_word_b", 96'(outs()),
            96'({1'b1, 1'b1, 3'd7, 3'd3, 1'b0, 1'b0, 1'b1, put(BG, 3, EB)}));
        drive(BG, 1, 1);
        @(posedge clk); #1;
        chk("bp_word_c", 96'(outs()),
            96'({1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 1'b1, 1'b1, BG}));
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("bp_drain", 96'(out_valid), 96'd0);

        // Asynchronous reset while a region is open.
        drive(put(BG, 4, SB), 1, 0);
        @(posedge clk); #1;
        chk("rst_pre_open", 96'({out_hit, out_first}), 96'({1'b1, 3'd4}));
        in_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("rst_async_outs", 96'(outs()), 96'd0);
`ifdef REGION_LOCATOR_STATS_EN
        chk("rst_stats", 96'({stat_regions, stat_truncs}), 96'd0);
`endif
        @(negedge clk);
        reset_n = 1'b1;
        drive(put(BG, 5, EB), 0, 1);
        @(posedge clk); #1;
        chk("rst_post_idle", 96'(outs()),
            96'({1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, put(BG, 5, EB)}));
        in_valid = 1'b0;
        @(posedge clk); #1;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
